// File: rtl/inst_mem_pkg.sv
// Shared constants for the 16-bit CPU instruction memory: default widths,
// the power-up / reset program image, and a helper that returns the reset
// value of any byte address.
package inst_mem_pkg;

    localparam int DEFAULT_ADDR_W  = 8;
    localparam int DEFAULT_INSTR_W = 16;

    // Only the first IMAGE_LEN bytes carry program content; every byte
    // above that resets to zero.
    localparam int unsigned IMAGE_LEN = 16;

    // Big-endian program words: 0x1120, 0x2132, 0x3244, 0x4356, 0x5468,
    // 0x657A, 0x768C, followed by two zero pad bytes.
    localparam logic [7:0] DEFAULT_IMAGE [IMAGE_LEN] = '{
        8'h11, 8'h20, 8'h21, 8'h32, 8'h32, 8'h44, 8'h43, 8'h56,
        8'h54, 8'h68, 8'h65, 8'h7A, 8'h76, 8'h8C, 8'h00, 8'h00
    };

    // Reset value of the byte stored at addr.
    function automatic logic [7:0] image_byte(input int unsigned addr);
        if (addr < IMAGE_LEN) begin
            return DEFAULT_IMAGE[addr[3:0]];
        end
        return 8'h00;
    endfunction

endpackage

// File: rtl/inst_mem_byte_lane.sv
// One byte of writable instruction memory: an asynchronously reset register
// that reloads its image value whenever reset is low and otherwise captures
// write data on a rising clock when enabled.
module inst_mem_byte_lane #(
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_wrEn,
    input  logic [7:0] i_wrData,
    output logic [7:0] o_q
);

    logic [7:0] r_q;

    // Byte storage: image value under reset, load data on an enabled edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= RESET_VAL;
        end else if (i_wrEn) begin
            r_q <= i_wrData;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/inst_mem.sv
// Byte-addressed, big-endian instruction memory for the 16-bit CPU.
// The instruction at Address is presented combinationally as
// {mem[Address], mem[Address+1]}, with the upper address wrapping to 0.
// Build option INST_MEM_LOAD_EN adds a clocked 16-bit load port; without it
// the contents are the fixed default image and the memory is a pure ROM.
// Only a 16-bit INSTR_W is supported: one instruction is always two bytes.
module inst_mem
    import inst_mem_pkg::*;
#(
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int INSTR_W = DEFAULT_INSTR_W
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic [ADDR_W-1:0]  Address,
`ifdef INST_MEM_LOAD_EN
    input  logic               Load_En,
    input  logic [ADDR_W-1:0]  Load_Addr,
    input  logic [INSTR_W-1:0] Load_Data,
`endif
    output logic [INSTR_W-1:0] Instruction,
    output logic               Misaligned
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [7:0]        w_mem [DEPTH];
    logic [ADDR_W-1:0] w_addrNext;

    // The low byte comes from the next address; natural overflow of the
    // ADDR_W-bit sum gives the wrap from the top byte back to byte 0.
    assign w_addrNext = Address + 1'b1;

`ifdef INST_MEM_LOAD_EN
    logic [ADDR_W-1:0] w_loadAddrNext;

    assign w_loadAddrNext = Load_Addr + 1'b1;

    // Each byte is written either as the high half of a load (its address
    // equals Load_Addr) or as the low half (it follows Load_Addr). With at
    // least two bytes of depth the two cases never coincide.
    for (genvar i = 0; i < DEPTH; i++) begin : g_lane
        logic       w_hiHit;
        logic       w_loHit;
        logic [7:0] w_wrData;

        assign w_hiHit  = (Load_Addr == ADDR_W'(i));
        assign w_loHit  = (w_loadAddrNext == ADDR_W'(i));
        assign w_wrData = w_hiHit ? Load_Data[15:8] : Load_Data[7:0];

        inst_mem_byte_lane #(
            .RESET_VAL (image_byte(i))
        ) u_lane (
            .i_clk    (Clk),
            .i_rst_n  (Rst),
            .i_wrEn   (Load_En && (w_hiHit || w_loHit)),
            .i_wrData (w_wrData),
            .o_q      (w_mem[i])
        );
    end
`else
    logic w_unused;

    // Clock and reset have nothing to act on when the contents are fixed.
    assign w_unused = Clk ^ Rst;

    // Constant storage: every byte is its default image value.
    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        assign w_mem[i] = image_byte(i);
    end
`endif

    // Zero-latency fetch path, high byte at the lower address.
    assign Instruction = {w_mem[Address], w_mem[w_addrNext]};

    // Odd addresses still read normally; they are only flagged.
    assign Misaligned = Address[0];

endmodule

// File: tb/tb_inst_mem.sv
// Directed testbench for inst_mem. Expected words are hand-derived from the
// default program image; the load-port section is built only when
// INST_MEM_LOAD_EN is defined.
module tb_inst_mem;

    logic        Clk;
    logic        Rst;
    logic [7:0]  Address;
    logic [15:0] Instruction;
    logic        Misaligned;
`ifdef INST_MEM_LOAD_EN
    logic        Load_En;
    logic [7:0]  Load_Addr;
    logic [15:0] Load_Data;
`endif

    int vectorCount = 0;
    int missCount   = 0;

    inst_mem dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .Address     (Address),
`ifdef INST_MEM_LOAD_EN
        .Load_En     (Load_En),
        .Load_Addr   (Load_Addr),
        .Load_Data   (Load_Data),
`endif
        .Instruction (Instruction),
        .Misaligned  (Misaligned)
    );

    // 10-unit clock; only the load port reacts to it.
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Present a new fetch address just after a falling edge, hold it for
    // ten cycles, then let the combinational read settle.
    task automatic applyStimulus(input logic [7:0] addr);
        @(negedge Clk);
        repeat (9) @(negedge Clk);
        Address = addr;
        #2;
    endtask

    // Compare both outputs against hand-computed values.
    task automatic checkOutput(input string tag, input logic [15:0] expInstr,
                               input logic expMis);
        vectorCount++;
        assert (Instruction === expInstr) else begin
            missCount++;
            $error("[TB] FAIL %s instr: observed %h expected %h", tag, Instruction, expInstr);
        end
        vectorCount++;
        assert (Misaligned === expMis) else begin
            missCount++;
            $error("[TB] FAIL %s misaligned: observed %b expected %b", tag, Misaligned, expMis);
        end
    endtask

    // Linear directed sequence: reset, aligned reads, odd reads, wrap, loads.
    initial begin
        Rst     = 1'b0;
        Address = 8'h0A;
`ifdef INST_MEM_LOAD_EN
        Load_En   = 1'b0;
        Load_Addr = 8'h00;
        Load_Data = 16'h0000;
`endif
        #2;
        checkOutput("reset_0A", 16'h657A, 1'b0);
        #20;
        Rst = 1'b1;

        applyStimulus(8'h00); checkOutput("rd_00", 16'h1120, 1'b0);
        applyStimulus(8'h02); checkOutput("rd_02", 16'h2132, 1'b0);
        applyStimulus(8'h04); checkOutput("rd_04", 16'h3244, 1'b0);
        applyStimulus(8'h06); checkOutput("rd_06", 16'h4356, 1'b0);
        applyStimulus(8'h08); checkOutput("rd_08", 16'h5468, 1'b0);
        applyStimulus(8'h0A); checkOutput("rd_0A", 16'h657A, 1'b0);
        applyStimulus(8'h0C); checkOutput("rd_0C", 16'h768C, 1'b0);

        applyStimulus(8'h01); checkOutput("odd_01", 16'h2021, 1'b1);
        applyStimulus(8'h03); checkOutput("odd_03", 16'h3232, 1'b1);
        applyStimulus(8'h0B); checkOutput("odd_0B", 16'h7A76, 1'b1);
        applyStimulus(8'h0D); checkOutput("odd_0D", 16'h8C00, 1'b1);
        applyStimulus(8'h0E); checkOutput("rd_0E", 16'h0000, 1'b0);
        applyStimulus(8'h80); checkOutput("rd_80", 16'h0000, 1'b0);
        applyStimulus(8'hFE); checkOutput("rd_FE", 16'h0000, 1'b0);
        applyStimulus(8'hFF); checkOutput("wrap_FF", 16'h0011, 1'b1);

`ifdef INST_MEM_LOAD_EN
        // Write 0xBEEF at 0x04: old word before the edge, new word after it.
        @(negedge Clk);
        Address   = 8'h04;
        Load_En   = 1'b1;
        Load_Addr = 8'h04;
        Load_Data = 16'hBEEF;
        #1;
        checkOutput("ld_before", 16'h3244, 1'b0);
        @(posedge Clk);
        #1;
        Load_En = 1'b0;
        checkOutput("ld_after", 16'hBEEF, 1'b0);

        // Reset without a clock edge restores the image at once.
        #1;
        Rst = 1'b0;
        #1;
        checkOutput("ld_rst", 16'h3244, 1'b0);
        #1;
        Rst = 1'b1;

        // Wrapping load at 0xFF: high byte to 0xFF, low byte to 0x00.
        @(negedge Clk);
        Load_En   = 1'b1;
        Load_Addr = 8'hFF;
        Load_Data = 16'hA55A;
        @(posedge Clk);
        #1;
        Load_En = 1'b0;
        Address = 8'hFE;
        #1;
        checkOutput("ldwrap_FE", 16'h00A5, 1'b0);
        Address = 8'h00;
        #1;
        checkOutput("ldwrap_00", 16'h5A20, 1'b0);

        // Reset held low must override an active load across several edges.
        @(negedge Clk);
        Rst       = 1'b0;
        Load_En   = 1'b1;
        Load_Addr = 8'h00;
        Load_Data = 16'hFFFF;
        repeat (3) @(posedge Clk);
        #1;
        checkOutput("rst_override", 16'h1120, 1'b0);
        @(negedge Clk);
        Load_En = 1'b0;
        Rst     = 1'b1;
        #1;
        checkOutput("rst_release", 16'h1120, 1'b0);
`else
        // Without the load port, reset must not disturb the contents.
        @(negedge Clk);
        Address = 8'h06;
        Rst     = 1'b0;
        #1;
        checkOutput("rom_rst", 16'h4356, 1'b0);
        #1;
        Rst = 1'b1;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
